cache_controller: RTL and testbench

//  Blocking, single-outstanding cache controller; drives the set/way/tag/write port of the cache data+tag array.

---
 rtl/cache_pkg.sv | 38 +++
 rtl/cache_victim_select.sv | 36 +++
 rtl/cache_controller.sv | 271 +++++++++++++++++++++++++++
 tb/tb_cache_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the blocking cache controller:
//   - cache_state_e : controller FSM states
//   - *_size_f      : field widths derived from the top-level parameters
// No ports (package).
// ---------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        RESP     = 3'd4
    } cache_state_e;

    // Number of bits needed to index the sets of the array.
    function automatic int set_size_f(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Number of bits needed to select a way.
    function automatic int way_size_f(input int num_ways);
        return $clog2(num_ways);
    endfunction

    // Low address bits below the set index (line offset).
    function automatic int byte_offset_size_f(input int block_size);
        return $clog2(block_size / 4);
    endfunction

    // Remaining upper address bits form the tag.
    function automatic int tag_size_f(input int addr_size, input int num_sets, input int block_size);
        return addr_size - $clog2(num_sets) - $clog2(block_size / 4);
    endfunction

endpackage

// File: rtl/cache_victim_select.sv
// ---------------------------------------------------------------------------
// cache_victim_select
// Purely combinational replacement choice for a read miss.
// The lowest-numbered invalid way is preferred; only when every way of the
// set is valid does the per-set round-robin pointer decide.
// Ports:
//   i_valid_flags  in  NUM_WAYS  per-way valid flags of the addressed set
//   i_rr_ptr       in  WAY_SIZE  round-robin pointer of the addressed set
//   o_victim       out WAY_SIZE  way to refill
//   o_used_rr      out 1         1 when o_victim came from i_rr_ptr
// ---------------------------------------------------------------------------
module cache_victim_select
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    localparam int WAY_SIZE = way_size_f(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] i_valid_flags,
    input  logic [WAY_SIZE-1:0] i_rr_ptr,
    output logic [WAY_SIZE-1:0] o_victim,
    output logic                o_used_rr
);

    // Scan from the top down so the lowest invalid way is the last to win.
    always_comb begin
        o_victim  = i_rr_ptr;
        o_used_rr = 1'b1;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!i_valid_flags[i]) begin
                o_victim  = WAY_SIZE'(i);
                o_used_rr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
// Blocking, single-outstanding cache controller between a CPU load/store port
// and main memory. Write-through, no-write-allocate, read-allocate. It drives
// the way/set/tag/write port of an external data+tag array.
//
// Optional feature: define CACHE_PERF_COUNTERS_EN to add the 32-bit outputs
// hit_count / miss_count (one increment per LOOKUP cycle, wrap at 2^32).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req_valid/ready/write/addr/wdata   CPU request (ready only in IDLE)
//   cpu_resp_valid/rdata           one-cycle completion pulse, load data (0 for stores)
//   mem_req_valid/ready/write/addr/wdata   memory request (refill read or write-through)
//   mem_resp_valid/rdata           refill data
//   cm_way/set/tag                 array addressing (set/tag from latched address)
//   cm_write_enable/write_data     array write strobe and data
//   cm_read_data                   array read data (combinational from way/set)
//   cm_hits, cm_valid_flags        per-way hit and valid flags for cm_set/cm_tag
//   hit_count, miss_count          performance counters (CACHE_PERF_COUNTERS_EN only)
// ---------------------------------------------------------------------------
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 4,
    parameter int BLOCK_SIZE = 32,
    localparam int SET_SIZE         = set_size_f(NUM_SETS),
    localparam int WAY_SIZE         = way_size_f(NUM_WAYS),
    localparam int BYTE_OFFSET_SIZE = byte_offset_size_f(BLOCK_SIZE),
    localparam int TAG_SIZE         = tag_size_f(ADDR_SIZE, NUM_SETS, BLOCK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU side
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_write,
    input  logic [ADDR_SIZE-1:0]  cpu_req_addr,
    input  logic [BLOCK_SIZE-1:0] cpu_req_wdata,
    output logic                  cpu_resp_valid,
    output logic [BLOCK_SIZE-1:0] cpu_resp_rdata,
    // memory side
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_SIZE-1:0]  mem_req_addr,
    output logic [BLOCK_SIZE-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [BLOCK_SIZE-1:0] mem_resp_rdata,
    // cache array side
    output logic [WAY_SIZE-1:0]   cm_way,
    output logic [SET_SIZE-1:0]   cm_set,
    output logic [TAG_SIZE-1:0]   cm_tag,
    output logic                  cm_write_enable,
    output logic [BLOCK_SIZE-1:0] cm_write_data,
    input  logic [BLOCK_SIZE-1:0] cm_read_data,
    input  logic [NUM_WAYS-1:0]   cm_hits,
    input  logic [NUM_WAYS-1:0]   cm_valid_flags
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    cache_state_e          r_state;
    logic                  r_write;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [BLOCK_SIZE-1:0] r_wdata;
    logic [WAY_SIZE-1:0]   r_victim;
    logic                  r_victim_rr;
    logic                  r_cpu_resp_valid;
    logic [BLOCK_SIZE-1:0] r_cpu_resp_rdata;
    logic                  r_mem_req_valid;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic [SET_SIZE-1:0]          w_set;
    logic                         w_hit;
    logic [WAY_SIZE-1:0]          w_hit_way;
    logic [WAY_SIZE-1:0]          w_victim;
    logic                         w_used_rr;
    logic [NUM_SETS*WAY_SIZE-1:0] w_rr_flat;
    logic [WAY_SIZE-1:0]          w_rr_cur;
    logic                         w_rr_advance;

    assign w_set  = r_addr[BYTE_OFFSET_SIZE +: SET_SIZE];
    assign cm_set = w_set;
    assign cm_tag = r_addr[ADDR_SIZE-1 -: TAG_SIZE];

    // Multiple hits can only come from a corrupted array; the lowest way wins.
    assign w_hit = |cm_hits;
    always_comb begin
        w_hit_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (cm_hits[i]) begin
                w_hit_way = WAY_SIZE'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-set round-robin pointers, flattened so the addressed one can be
    // picked with a part-select.
    // ------------------------------------------------------------------
    assign w_rr_advance = (r_state == MEM_WAIT) && mem_resp_valid && r_victim_rr;

    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_rr
        logic [WAY_SIZE-1:0] r_ptr;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ptr <= '0;
            end else if (w_rr_advance && (w_set == SET_SIZE'(gi))) begin
                r_ptr <= (r_ptr == WAY_SIZE'(NUM_WAYS - 1)) ? '0 : r_ptr + 1'b1;
            end
        end

        assign w_rr_flat[gi*WAY_SIZE +: WAY_SIZE] = r_ptr;
    end

    assign w_rr_cur = w_rr_flat[w_set*WAY_SIZE +: WAY_SIZE];

    cache_victim_select #(
        .NUM_WAYS (NUM_WAYS)
    ) u_victim_select (
        .i_valid_flags (cm_valid_flags),
        .i_rr_ptr      (w_rr_cur),
        .o_victim      (w_victim),
        .o_used_rr     (w_used_rr)
    );

    // ------------------------------------------------------------------
    // Array write port. The write must land in the same cycle as the hit
    // lookup or the refill beat, so it is driven combinationally from the
    // state. Reset suppresses any write, including a refill racing the reset.
    // ------------------------------------------------------------------
    always_comb begin
        cm_way          = '0;
        cm_write_enable = 1'b0;
        cm_write_data   = '0;
        case (r_state)
            LOOKUP: begin
                // Hit way also steers cm_read_data for a load hit.
                cm_way = w_hit_way;
                if (r_write && w_hit && !rst) begin
                    cm_write_enable = 1'b1;
                    cm_write_data   = r_wdata;
                end
            end
            MEM_WAIT: begin
                cm_way = r_victim;
                if (mem_resp_valid && !rst) begin
                    cm_write_enable = 1'b1;
                    cm_write_data   = mem_resp_rdata;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_write          <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_victim         <= '0;
            r_victim_rr      <= 1'b0;
            r_cpu_resp_valid <= 1'b0;
            r_cpu_resp_rdata <= '0;
            r_mem_req_valid  <= 1'b0;
        end else begin
            r_cpu_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        r_write <= cpu_req_write;
                        r_addr  <= cpu_req_addr;
                        r_wdata <= cpu_req_wdata;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (r_write) begin
                        // Stores always go through to memory, hit or miss.
                        r_mem_req_valid <= 1'b1;
                        r_state         <= MEM_REQ;
                    end else if (w_hit) begin
                        r_cpu_resp_rdata <= cm_read_data;
                        r_cpu_resp_valid <= 1'b1;
                        r_state          <= RESP;
                    end else begin
                        r_victim        <= w_victim;
                        r_victim_rr     <= w_used_rr;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        if (r_write) begin
                            r_cpu_resp_rdata <= '0;
                            r_cpu_resp_valid <= 1'b1;
                            r_state          <= RESP;
                        end else begin
                            r_state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        r_cpu_resp_rdata <= mem_resp_rdata;
                        r_cpu_resp_valid <= 1'b1;
                        r_state          <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_req_ready  = (r_state == IDLE);
    assign cpu_resp_valid = r_cpu_resp_valid;
    assign cpu_resp_rdata = r_cpu_resp_rdata;

    // Request fields come only from the latched request, so they stay stable
    // for the whole MEM_REQ phase regardless of mem_req_ready.
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_write = r_write;
    assign mem_req_wdata = r_wdata;
    assign mem_req_addr  = r_write ? r_addr
                                   : {r_addr[ADDR_SIZE-1:BYTE_OFFSET_SIZE], {BYTE_OFFSET_SIZE{1'b0}}};

`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == LOOKUP) begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end else begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_controller
// Self-checking bench for cache_controller. The bench models the external
// data+tag array (written by the DUT), a main memory, and an independent
// set-associative reference cache that predicts hit/miss, victim way, memory
// traffic, response data and response latency for every transaction.
// ---------------------------------------------------------------------------
module tb_cache_controller;

    localparam int AW = 32;
    localparam int NS = 16;
    localparam int NW = 4;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic          cpu_req_write;
    logic [AW-1:0] cpu_req_addr;
    logic [BW-1:0] cpu_req_wdata;
    logic          cpu_resp_valid;
    logic [BW-1:0] cpu_resp_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [BW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [BW-1:0] mem_resp_rdata;
    logic [1:0]    cm_way;
    logic [3:0]    cm_set;
    logic [24:0]   cm_tag;
    logic          cm_write_enable;
    logic [BW-1:0] cm_write_data;
    logic [BW-1:0] cm_read_data;
    logic [NW-1:0] cm_hits;
    logic [NW-1:0] cm_valid_flags;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    always #5 clk = ~clk;

    cache_controller #(
        .ADDR_SIZE (AW), .NUM_SETS (NS), .NUM_WAYS (NW), .BLOCK_SIZE (BW)
    ) dut (
        .clk (clk), .rst (rst),
        .cpu_req_valid (cpu_req_valid), .cpu_req_ready (cpu_req_ready),
        .cpu_req_write (cpu_req_write), .cpu_req_addr (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata), .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready),
        .mem_req_write (mem_req_write), .mem_req_addr (mem_req_addr),
        .mem_req_wdata (mem_req_wdata), .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .cm_way (cm_way), .cm_set (cm_set), .cm_tag (cm_tag),
        .cm_write_enable (cm_write_enable), .cm_write_data (cm_write_data),
        .cm_read_data (cm_read_data), .cm_hits (cm_hits),
        .cm_valid_flags (cm_valid_flags)
`ifdef CACHE_PERF_COUNTERS_EN
        , .hit_count (hit_count), .miss_count (miss_count)
`endif
    );

    // ---------------- external array emulation ----------------
    logic [BW-1:0] arr_data  [NS][NW];
    logic [24:0]   arr_tag   [NS][NW];
    logic          arr_valid [NS][NW];
    logic          arr_clear;

    always @(posedge clk) begin
        if (arr_clear) begin
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++)
                    arr_valid[s][w] <= 1'b0;
        end else if (cm_write_enable) begin
            arr_valid[cm_set][cm_way] <= 1'b1;
            arr_tag[cm_set][cm_way]   <= cm_tag;
            arr_data[cm_set][cm_way]  <= cm_write_data;
        end
    end

    always_comb begin
        cm_hits        = '0;
        cm_valid_flags = '0;
        for (int w = 0; w < NW; w++) begin
            cm_valid_flags[w] = arr_valid[cm_set][w];
            cm_hits[w]        = arr_valid[cm_set][w] && (arr_tag[cm_set][w] == cm_tag);
        end
        cm_read_data = arr_data[cm_set][cm_way];
    end

    // ---------------- main memory model ----------------
    logic [31:0] mem_store [logic [31:0]];

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    // ---------------- reference cache ----------------
    bit          ref_valid [NS][NW];
    logic [24:0] ref_tag   [NS][NW];
    logic [31:0] ref_data  [NS][NW];
    int          ref_rr    [NS];
    int          exp_hits;
    int          exp_miss;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete CPU transaction: prediction, stimulus, observation, compare.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int rdy_d, input int rsp_d, input string tag);
        int          s;
        logic [24:0] t;
        logic [31:0] aligned;
        bit          hit;
        int          hway;
        int          vway;
        bit          used_rr;
        bit          e_cm;
        int          e_way;
        logic [31:0] e_cmdata;
        logic [31:0] e_maddr;
        logic [31:0] e_resp;
        int          e_cyc;
        int          cyc;
        int          vcnt;
        int          resp_at;
        int          n_cm;
        int          n_hs;
        int          o_way;
        int          o_set;
        logic [31:0] o_cmdata;
        bit          mem_seen;
        logic [31:0] o_maddr;
        logic        o_mwr;
        logic [31:0] o_mwdata;
        bit          unstable;
        bit          busy_ready;
        bit          got_resp;
        int          resp_cyc;
        logic [31:0] o_resp;

        s       = int'(addr[6:3]);
        t       = addr[31:7];
        aligned = {addr[31:3], 3'b000};
        hit     = 0;
        hway    = 0;
        for (int w = NW - 1; w >= 0; w--)
            if (ref_valid[s][w] && ref_tag[s][w] == t) begin hit = 1; hway = w; end

        vway = -1;
        used_rr = 0;
        e_cm = 0; e_way = 0; e_cmdata = '0; e_maddr = '0;
        if (wr) begin
            e_cm = hit; e_way = hway; e_cmdata = wdata;
            e_maddr = addr; e_resp = '0; e_cyc = 3 + rdy_d;
        end else if (hit) begin
            e_resp = ref_data[s][hway]; e_cyc = 2;
        end else begin
            for (int w = NW - 1; w >= 0; w--) if (!ref_valid[s][w]) vway = w;
            if (vway < 0) begin vway = ref_rr[s]; used_rr = 1; end
            e_cm = 1; e_way = vway; e_cmdata = memval(aligned);
            e_maddr = aligned; e_resp = memval(aligned); e_cyc = 4 + rdy_d + rsp_d;
        end

        // drive request
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = addr; cpu_req_wdata = wdata;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        chk({tag, "_accept_ready"}, cpu_req_ready, 1);

        cyc = 0; vcnt = 0; resp_at = -1; n_cm = 0; n_hs = 0; o_way = 0; o_set = 0;
        o_cmdata = '0; mem_seen = 0; o_maddr = '0; o_mwr = 0; o_mwdata = '0;
        unstable = 0; busy_ready = 0; got_resp = 0; resp_cyc = -1; o_resp = '0;
        while (!got_resp && cyc < 80) begin
            @(negedge clk);
            cyc++;
            cpu_req_valid = 1'b0;
            cpu_req_addr  = $urandom;
            if (resp_at < 0) begin
                // stray responses before the refill handshake must be ignored
                mem_resp_valid = ($urandom_range(0, 3) == 0);
                mem_resp_rdata = $urandom;
            end else begin
                mem_resp_valid = (resp_at == cyc);
                mem_resp_rdata = (resp_at == cyc) ? memval(aligned) : $urandom;
            end
            if (mem_req_valid) begin
                mem_req_ready = (vcnt >= rdy_d);
                vcnt++;
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (cm_write_enable) begin
                n_cm++; o_way = int'(cm_way); o_set = int'(cm_set); o_cmdata = cm_write_data;
            end
            if (cpu_req_ready) busy_ready = 1;
            if (mem_req_valid) begin
                if (!mem_seen) begin
                    mem_seen = 1; o_maddr = mem_req_addr; o_mwr = mem_req_write; o_mwdata = mem_req_wdata;
                end else if (mem_req_addr !== o_maddr || mem_req_write !== o_mwr || mem_req_wdata !== o_mwdata) begin
                    unstable = 1;
                end
                if (mem_req_ready) begin
                    n_hs++;
                    if (!wr) resp_at = cyc + 1 + rsp_d;
                end
            end
            if (cpu_resp_valid) begin
                got_resp = 1; resp_cyc = cyc; o_resp = cpu_resp_rdata;
            end
        end

        chk({tag, "_resp_seen"}, got_resp, 1);
        chk({tag, "_latency"}, 64'(resp_cyc), 64'(e_cyc));
        chk({tag, "_rdata"}, o_resp, e_resp);
        chk({tag, "_busy_ready_low"}, busy_ready, 0);
        chk({tag, "_cm_writes"}, 64'(n_cm), 64'(e_cm));
        if (e_cm) begin
            chk({tag, "_cm_way"}, 64'(o_way), 64'(e_way));
            chk({tag, "_cm_set"}, 64'(o_set), 64'(s));
            chk({tag, "_cm_data"}, o_cmdata, e_cmdata);
        end
        chk({tag, "_mem_handshakes"}, 64'(n_hs), 64'((wr || !hit) ? 1 : 0));
        if (mem_seen) begin
            chk({tag, "_mem_addr"}, o_maddr, e_maddr);
            chk({tag, "_mem_write"}, o_mwr, wr);
            if (wr) chk({tag, "_mem_wdata"}, o_mwdata, wdata);
            chk({tag, "_mem_stable"}, unstable, 0);
        end

        // completion is a single pulse and the controller is idle again
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        #1;
        chk({tag, "_pulse_end"}, cpu_resp_valid, 0);
        chk({tag, "_idle_ready"}, cpu_req_ready, 1);
        chk({tag, "_idle_way"}, cm_way, 0);

        // reference update
        if (hit) exp_hits++; else exp_miss++;
        if (wr) begin
            mem_store[addr] = wdata;
            if (hit) ref_data[s][hway] = wdata;
        end else if (!hit) begin
            ref_valid[s][vway] = 1; ref_tag[s][vway] = t; ref_data[s][vway] = memval(aligned);
            if (used_rr) ref_rr[s] = (ref_rr[s] + 1) % NW;
        end
        $display("txn %-10s %s addr=%08h %s rdata=%08h latency=%0d", tag, wr ? "ST" : "LD",
                 addr, hit ? "hit " : "miss", o_resp, resp_cyc);
    endtask

    initial begin
        logic [31:0] a;
        int          st;
        checks = 0; errors = 0; exp_hits = 0; exp_miss = 0;
        for (int s2 = 0; s2 < NS; s2++) begin
            ref_rr[s2] = 0;
            for (int w = 0; w < NW; w++) ref_valid[s2][w] = 0;
        end
        mem_store[32'h40] = 32'hDEAD_BEEF;

        rst = 1'b1; arr_clear = 1'b1;
        cpu_req_valid = 0; cpu_req_write = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_resp_valid", cpu_resp_valid, 0);
        chk("reset_resp_rdata", cpu_resp_rdata, 0);
        chk("reset_mem_req_valid", mem_req_valid, 0);
        chk("reset_cm_we", cm_write_enable, 0);
        chk("reset_ready", cpu_req_ready, 1);
        chk("reset_cm_way", cm_way, 0);
        rst = 1'b0; arr_clear = 1'b0;

        // read miss then read hit on 0x40
        txn(0, 32'h40, '0, 0, 0, "s1_miss");
        txn(0, 32'h40, '0, 0, 0, "s2_hit");
`ifdef CACHE_PERF_COUNTERS_EN
        #1;
        chk("perf_s12_miss", miss_count, 1);
        chk("perf_s12_hit", hit_count, 1);
`endif
        // fill the set, evict, re-miss
        for (int k = 1; k <= 4; k++) txn(0, 32'h40 + k * 32'h80, '0, 0, 1, "s3_fill");
        txn(0, 32'h40, '0, 0, 0, "s3_remiss");
        txn(0, 32'h45, '0, 0, 0, "s3_offs_hit");
        // stores
        txn(1, 32'h40, 32'h1234_5678, 0, 0, "s4_st_hit");
        txn(0, 32'h40, '0, 0, 0, "s4_ld");
        txn(1, 32'h1000, 32'hCAFE_F00D, 0, 0, "s4_st_miss");
        txn(0, 32'h1004, '0, 1, 0, "s4_ld_wt");
        // memory back-pressure
        txn(0, 32'h3300, '0, 5, 2, "s5_rd_stall");
        txn(1, 32'h3300, 32'h0BAD_CAFE, 5, 0, "s5_wr_stall");

        // reset while waiting for refill data; late data must not be written
        @(negedge clk);
        cpu_req_valid = 1; cpu_req_write = 0; cpu_req_addr = 32'h2C0; mem_req_ready = 1; mem_resp_valid = 0;
        @(negedge clk);
        cpu_req_valid = 0;
        @(negedge clk);
        #1;
        chk("s5_rst_mem_req", mem_req_valid, 1);
        @(negedge clk);
        rst = 1; mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0_BAD0;
        #1;
        chk("s5_rst_no_cm_wr", cm_write_enable, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("s5_rst_mem_req_low", mem_req_valid, 0);
        chk("s5_rst_idle", cpu_req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("s5_late_no_cm_wr", cm_write_enable, 0);
            chk("s5_late_no_resp", cpu_resp_valid, 0);
        end
        mem_resp_valid = 0;
        for (int s2 = 0; s2 < NS; s2++) ref_rr[s2] = 0;
        exp_hits = 0; exp_miss = 0;
        txn(0, 32'h2C0, '0, 0, 0, "s5_after_rst");

        // randomized traffic over a small address pool to force evictions
        for (int n = 0; n < 150; n++) begin
            st = $urandom_range(0, 2);
            if (st == 2) st = 8;
            a = (32'($urandom_range(0, 5)) << 7) | (32'(st) << 3);
            txn(($urandom_range(0, 9) < 3), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end

`ifdef CACHE_PERF_COUNTERS_EN
        #1;
        chk("perf_end_hit", hit_count, 32'(exp_hits));
        chk("perf_end_miss", miss_count, 32'(exp_miss));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
